watch_mode_hub: RTL and testbench

WATCH_MODE_HUB -- requirements
Module: watch_mode_hub

---
 rtl/watch_mode_hub.sv | 135 +++++++++++++
 tb/tb_watch_mode_hub.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_mode_hub.sv
// Mode hub for a multi-mode watch: debounces six raw buttons, steps the
// active mode with left/right, muxes the active channel's display and latches alarms.
module watch_mode_hub #(
  parameter int N_MODES  = 7,
  parameter int DISP_W   = 48,
  parameter int DEB_CYC  = 4,
  parameter int ALARM_TO = 1000,
  parameter int RST_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5:0]                btn_n,
  input  logic [N_MODES-1:0]        norm_i,
  input  logic [N_MODES*DISP_W-1:0] disp_i,
  input  logic [N_MODES-1:0]        alarm_i,
  output logic [5:0]                btn_o,
  output logic [N_MODES-1:0]        mode_o,
  output logic [7:0]                o_m,
  output logic [DISP_W-1:0]         out,
  output logic                      alarm
);

  localparam int IDX_W   = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int DC_W    = $clog2(DEB_CYC + 1);
  localparam int TO_W    = $clog2(ALARM_TO + 1);
  localparam int B_RIGHT = 2;
  localparam int B_LEFT  = 3;
  localparam int B_ESC   = 5;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_MODES - 1);
  localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(RST_MODE);

  logic [5:0]         sync1_q, sync2_q;
  logic [5:0]         pressed, deb_lvl, deb_prev_q, rise;
  logic [5:0]         pulse_q, cons_q, cons_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_MODES-1:0] pend_q, pend_d, alarm_prev_q;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [DISP_W-1:0]  out_q;
  logic               alarm_q;
  logic               rise_left, rise_right, ack, timeout;

  // Synchroniser holds the raw active-low level; released == all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
      logic [DC_W-1:0] cnt_q;
      logic            lvl_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else if (pressed[gi] != lvl_q) begin
          if (cnt_q == DC_W'(DEB_CYC - 1)) begin
            lvl_q <= pressed[gi];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign deb_lvl[gi] = lvl_q;
    end
  endgenerate

  // Rising edge of the debounced level; acted on at the edge that registers the pulse.
  assign rise       = deb_lvl & ~deb_prev_q;
  assign rise_left  = rise[B_LEFT];
  assign rise_right = rise[B_RIGHT];

  always_comb begin
    cons_d = '0;
    idx_d  = idx_q;
    if (rise_left && rise_right) begin
      cons_d[B_LEFT]  = 1'b1;
      cons_d[B_RIGHT] = 1'b1;
    end else if ((rise_left || rise_right) && norm_i[idx_q]) begin
      cons_d[B_LEFT]  = rise_left;
      cons_d[B_RIGHT] = rise_right;
      if (rise_right) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      else            idx_d = (idx_q == '0) ? IDX_MAX : idx_q - 1'b1;
    end
    ack           = rise[B_ESC] && (pend_q != '0);
    cons_d[B_ESC] = ack;
    timeout       = (pend_q != '0) && (to_cnt_q == TO_W'(ALARM_TO - 1));
    // New alarm edges win over a same-cycle acknowledge or timeout.
    pend_d   = ((ack || timeout) ? '0 : pend_q) | (alarm_i & ~alarm_prev_q);
    to_cnt_d = (ack || timeout || (pend_d != pend_q) || (pend_q == '0)) ? '0 : to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev_q   <= '0;
      pulse_q      <= '0;
      cons_q       <= '0;
      idx_q        <= IDX_RST;
      pend_q       <= '0;
      alarm_prev_q <= '0;
      to_cnt_q     <= '0;
      alarm_q      <= 1'b0;
      out_q        <= '0;
    end else begin
      deb_prev_q   <= deb_lvl;
      pulse_q      <= rise;
      cons_q       <= cons_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      alarm_prev_q <= alarm_i;
      to_cnt_q     <= to_cnt_d;
      alarm_q      <= |pend_q;
      out_q        <= disp_i[idx_q*DISP_W +: DISP_W];
    end
  end

  assign btn_o  = pulse_q & ~cons_q;
  assign mode_o = {{(N_MODES-1){1'b0}}, 1'b1} << idx_q;
  assign o_m    = 8'(idx_q);
  assign out    = out_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_watch_mode_hub.sv
// Bench for watch_mode_hub: directed scenarios plus a randomized run, all
// checked against a timestamp-based behavioural model of the button/mode/alarm rules.
module tb_watch_mode_hub;
  localparam int N  = 7;
  localparam int DW = 48;
  localparam int DC = 4;
  localparam int AT = 20;
  localparam int RM = 0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [5:0]      btn_n = '1;
  logic [N-1:0]    norm_i = '1;
  logic [N*DW-1:0] disp_i = '0;
  logic [N-1:0]    alarm_i = '0;
  logic [5:0]      btn_o;
  logic [N-1:0]    mode_o;
  logic [7:0]      o_m;
  logic [DW-1:0]   out;
  logic            alarm;

  int checks = 0;
  int failures = 0;

  watch_mode_hub #(.N_MODES(N), .DISP_W(DW), .DEB_CYC(DC), .ALARM_TO(AT), .RST_MODE(RM)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .norm_i(norm_i), .disp_i(disp_i),
    .alarm_i(alarm_i), .btn_o(btn_o), .mode_o(mode_o), .o_m(o_m), .out(out), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Behavioural model state (values after the most recent modelled edge)
  int          cyc;
  logic [5:0]  m_s1, m_s2, m_deb, m_deb_seen;
  int          m_last_eq [6];
  int          m_idx;
  logic [5:0]  m_btn;
  logic [DW-1:0] m_out;
  logic        m_alarm;
  logic [N-1:0] m_pend, m_prev_al;
  int          m_last_evt;

  function automatic void model_reset();
    m_s1 = '1; m_s2 = '1; m_deb = '0; m_deb_seen = '0;
    for (int b = 0; b < 6; b++) m_last_eq[b] = cyc;
    m_idx = RM; m_btn = '0; m_out = '0; m_alarm = 1'b0;
    m_pend = '0; m_prev_al = '0; m_last_evt = cyc;
  endfunction

  function automatic void model_edge();
    logic [5:0]   rise, cons;
    logic [N-1:0] np;
    logic         smp, ack, to;
    int           old_idx;
    cyc++;
    rise = m_deb & ~m_deb_seen;
    m_deb_seen = m_deb;
    for (int b = 0; b < 6; b++) begin
      smp = ~m_s2[b];
      if (smp == m_deb[b]) m_last_eq[b] = cyc;
      else if (cyc - m_last_eq[b] >= DC) begin
        m_deb[b] = smp;
        m_last_eq[b] = cyc;
      end
    end
    m_s2 = m_s1; m_s1 = btn_n;
    old_idx = m_idx; cons = '0;
    if (rise[3] && rise[2]) cons[3:2] = 2'b11;
    else if ((rise[3] || rise[2]) && norm_i[old_idx]) begin
      cons[3] = rise[3]; cons[2] = rise[2];
      m_idx = rise[2] ? (old_idx + 1) % N : (old_idx + N - 1) % N;
    end
    ack = rise[5] && (m_pend != 0);
    cons[5] = ack;
    m_btn = rise & ~cons;
    m_out = disp_i[old_idx*DW +: DW];
    m_alarm = (m_pend != 0);
    to = (m_pend != 0) && (cyc - m_last_evt >= AT);
    np = (ack || to) ? '0 : m_pend;
    np = np | (alarm_i & ~m_prev_al);
    m_prev_al = alarm_i;
    if (np != m_pend || ack || to) m_last_evt = cyc;
    m_pend = np;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_disp();
    for (int k = 0; k < N; k++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      disp_i[k*DW +: DW] = r[DW-1:0];
    end
  endtask

  // Hold button b for 'hold' edges, then release for 'tail' edges.
  task automatic press(input int b, input int hold, input int tail, output int pulses, output int first_edge);
    pulses = 0; first_edge = 0;
    btn_n[b] = 1'b0;
    for (int i = 1; i <= hold + tail; i++) begin
      if (i == hold + 1) btn_n[b] = 1'b1;
      step();
      if (btn_o[b]) begin
        pulses++;
        if (first_edge == 0) first_edge = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_n = '1; norm_i = '1; alarm_i = '0;
    rand_disp();
    repeat (3) @(negedge clk);
    checks++; if (btn_o !== 6'd0) begin failures++; $display("FAIL reset_btn_o got=%h exp=00", btn_o); end
    checks++; if (o_m !== 8'(RM)) begin failures++; $display("FAIL reset_o_m got=%0d exp=%0d", o_m, RM); end
    checks++; if (mode_o !== N'(1 << RM)) begin failures++; $display("FAIL reset_mode_o got=%b", mode_o); end
    checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", out); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    model_reset();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_right_press();
    int pulses;
    pulses = 0;
    btn_n[2] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (btn_o[2]) pulses++;
      if (e == DC + 2) begin
        checks++; if (o_m !== 8'd0) begin failures++; $display("FAIL right_early o_m got=%0d exp=0 edge=%0d", o_m, e); end
      end
      if (e == DC + 3) begin
        checks++; if (o_m !== 8'd1) begin failures++; $display("FAIL right_idx o_m got=%0d exp=1 edge=%0d", o_m, e); end
        checks++; if (mode_o !== N'(2)) begin failures++; $display("FAIL right_mode_o got=%b exp=%b", mode_o, N'(2)); end
      end
      if (e == DC + 4) begin
        checks++; if (out !== disp_i[DW +: DW]) begin failures++; $display("FAIL right_out got=%h exp=%h", out, disp_i[DW +: DW]); end
      end
    end
    btn_n[2] = 1'b1;
    repeat (10) step();
    checks++; if (pulses != 0) begin failures++; $display("FAIL right_consumed btn_o[2] pulses got=%0d exp=0", pulses); end
    $display("test_right_press done idx=%0d", o_m);
  endtask

  task automatic test_left_wrap();
    int p, f;
    press(3, 8, 10, p, f);
    checks++; if (o_m !== 8'd0) begin failures++; $display("FAIL left_step got=%0d exp=0", o_m); end
    press(3, 8, 10, p, f);
    checks++; if (o_m !== 8'(N - 1)) begin failures++; $display("FAIL left_wrap got=%0d exp=%0d", o_m, N - 1); end
    checks++; if (p != 0) begin failures++; $display("FAIL left_consumed pulses got=%0d exp=0", p); end
    press(2, 8, 10, p, f);
    checks++; if (o_m !== 8'd0) begin failures++; $display("FAIL right_wrap got=%0d exp=0", o_m); end
    $display("test_left_wrap done idx=%0d", o_m);
  endtask

  task automatic test_blocked();
    int p, f;
    norm_i = '1; norm_i[0] = 1'b0;
    press(2, 8, 10, p, f);
    checks++; if (p != 1) begin failures++; $display("FAIL blocked_right pulses got=%0d exp=1", p); end
    checks++; if (o_m !== 8'd0) begin failures++; $display("FAIL blocked_right_idx got=%0d exp=0", o_m); end
    press(3, 8, 10, p, f);
    checks++; if (p != 1) begin failures++; $display("FAIL blocked_left pulses got=%0d exp=1", p); end
    checks++; if (o_m !== 8'd0) begin failures++; $display("FAIL blocked_left_idx got=%0d exp=0", o_m); end
    norm_i = '1;
    $display("test_blocked done");
  endtask

  task automatic test_glitch();
    int p, f;
    press(4, 3, 12, p, f);
    checks++; if (p != 0) begin failures++; $display("FAIL glitch_short pulses got=%0d exp=0", p); end
    press(4, 8, 10, p, f);
    checks++; if (p != 1) begin failures++; $display("FAIL glitch_long pulses got=%0d exp=1", p); end
    checks++; if (f != DC + 3) begin failures++; $display("FAIL pulse_latency edge got=%0d exp=%0d", f, DC + 3); end
    $display("test_glitch done");
  endtask

  task automatic test_alarm();
    int p, f, cnt;
    alarm_i[4] = 1'b1;
    step();
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL alarm_latency0 got=%b exp=0", alarm); end
    step();
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_set got=%b exp=1", alarm); end
    press(5, 8, 10, p, f);
    checks++; if (p != 0) begin failures++; $display("FAIL esc_ack_consumed pulses got=%0d exp=0", p); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL esc_ack_alarm got=%b exp=0", alarm); end
    alarm_i = '0;
    step();
    press(5, 8, 10, p, f);
    checks++; if (p != 1) begin failures++; $display("FAIL esc_forward pulses got=%0d exp=1", p); end
    alarm_i[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < AT + 6; i++) begin
      step();
      if (alarm) cnt++;
    end
    checks++; if (cnt != AT) begin failures++; $display("FAIL alarm_timeout high_cycles got=%0d exp=%0d", cnt, AT); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL alarm_timeout_end got=%b exp=0", alarm); end
    alarm_i = '0;
    step();
    $display("test_alarm done");
  endtask

  task automatic test_async_reset();
    int p, f;
    for (int i = 0; i < 3; i++) press(2, 8, 10, p, f);
    checks++; if (o_m !== 8'd3) begin failures++; $display("FAIL pre_reset_idx got=%0d exp=3", o_m); end
    alarm_i[0] = 1'b1;
    step(); step();
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL pre_reset_alarm got=%b exp=1", alarm); end
    btn_n[0] = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL async_alarm got=%b exp=0", alarm); end
    checks++; if (out !== '0) begin failures++; $display("FAIL async_out got=%h exp=0", out); end
    checks++; if (o_m !== 8'(RM)) begin failures++; $display("FAIL async_idx got=%0d exp=%0d", o_m, RM); end
    checks++; if (btn_o !== 6'd0) begin failures++; $display("FAIL async_btn_o got=%h exp=00", btn_o); end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    f = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (btn_o[0] && f == 0) f = i;
    end
    checks++; if (f != DC + 3) begin failures++; $display("FAIL post_reset_debounce edge got=%0d exp=%0d", f, DC + 3); end
    btn_n = '1; alarm_i = '0;
    repeat (AT + 4) step();
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [N-1:0] exp_mode;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 9) == 0) btn_n[b] = ~btn_n[b];
      if ($urandom_range(0, 3) == 0) norm_i = N'($urandom | $urandom);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 19) == 0) alarm_i[k] = ~alarm_i[k];
      if ($urandom_range(0, 7) == 0) rand_disp();
      step();
      exp_mode = '0; exp_mode[m_idx] = 1'b1;
      checks++; if (btn_o !== m_btn) begin failures++; $display("FAIL rnd_btn_o cyc=%0d got=%h exp=%h", c, btn_o, m_btn); end
      checks++; if (o_m !== 8'(m_idx)) begin failures++; $display("FAIL rnd_o_m cyc=%0d got=%0d exp=%0d", c, o_m, m_idx); end
      checks++; if (mode_o !== exp_mode) begin failures++; $display("FAIL rnd_mode_o cyc=%0d got=%b exp=%b", c, mode_o, exp_mode); end
      checks++; if (out !== m_out) begin failures++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", c, out, m_out); end
      checks++; if (alarm !== m_alarm) begin failures++; $display("FAIL rnd_alarm cyc=%0d got=%b exp=%b", c, alarm, m_alarm); end
    end
    $display("test_random done");
  endtask

  initial begin
    cyc = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_right_press();
    test_left_wrap();
    test_blocked();
    test_glitch();
    test_alarm();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
